// File: rtl/serv_ifetch_pkg.sv
// Shared definitions for the SERV instruction fetch unit: FSM state
// encoding and sizing of the optional fetch watchdog counter.
package serv_ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // Counter width able to hold 0 .. cycles-1
    function automatic int unsigned wdog_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/serv_ifetch_wdog.sv
// Fetch watchdog: counts cycles spent waiting for ibus ack and flags
// expiry on the cycle that reaches TIMEOUT_CYCLES. Only instantiated when
// SERV_IFETCH_TIMEOUT_EN is defined.
module serv_ifetch_wdog
    import serv_ifetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int unsigned CNT_W          = wdog_width(TIMEOUT_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Count wait cycles while enabled, saturating on the final cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_clear) begin
            cnt <= '0;
        end else if (i_enable && (cnt != LAST)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_enable && (cnt == LAST);

endmodule

// File: rtl/serv_ifetch.sv
// SERV instruction fetch: issues one Wishbone read per accepted request,
// captures instruction bits [31:7] and strobes the decoder. Optional
// ack timeout is enabled with the macro SERV_IFETCH_TIMEOUT_EN.
module serv_ifetch
    import serv_ifetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch_req,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic [31:0] o_ibus_adr,
    output logic        o_ibus_cyc,
    input  logic [31:0] i_ibus_rdt,
    input  logic        i_ibus_ack,
    output logic        o_wb_en,
    output logic [24:0] o_wb_rdt,
    output logic        o_busy,
    output logic        o_misalign,
    output logic        o_fetch_err
);

    state_t      state;
    logic [29:0] pc_q;
    logic        cyc_q;
    logic [24:0] rdt_q;
    logic        wb_en_q;
    logic        err_q;
    logic        mis_q;
    logic        flush_q;
    logic        expire;
    logic        drop;

`ifdef SERV_IFETCH_TIMEOUT_EN
    serv_ifetch_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (state != S_REQ),
        .i_enable(state == S_REQ),
        .o_expire(expire)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign expire     = 1'b0;
`endif

    logic unused_rdt;
    assign unused_rdt = ^i_ibus_rdt[6:2];

    // A flush seen at any point in REQ, including the terminating cycle
    assign drop = flush_q | i_flush;

    // Fetch FSM with registered bus, capture and pulse outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_IDLE;
            pc_q    <= '0;
            cyc_q   <= 1'b0;
            rdt_q   <= '0;
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            wb_en_q <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_fetch_req) begin
                        if (i_pc[1:0] == 2'b00) begin
                            pc_q    <= i_pc[31:2];
                            cyc_q   <= 1'b1;
                            flush_q <= 1'b0;
                            state   <= S_REQ;
                        end else begin
                            mis_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (i_ibus_ack) begin
                        cyc_q   <= 1'b0;
                        rdt_q   <= i_ibus_rdt[31:7];
                        flush_q <= 1'b0;
                        state   <= S_DONE;
                        if (!drop) begin
                            if (i_ibus_rdt[1:0] == 2'b11) begin
                                wb_en_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end else if (expire) begin
                        cyc_q   <= 1'b0;
                        flush_q <= 1'b0;
                        state   <= S_IDLE;
                        err_q   <= !drop;
                    end else if (i_flush) begin
                        flush_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ibus_adr  = {pc_q, 2'b00};
    assign o_ibus_cyc  = cyc_q;
    assign o_wb_rdt    = rdt_q;
    // wb_en_q is only ever set for the DONE cycle, so a flush there gates it directly
    assign o_wb_en     = wb_en_q & ~i_flush;
    assign o_fetch_err = err_q;
    assign o_misalign  = mis_q;
    assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_serv_ifetch.sv
// Randomized scoreboard bench for serv_ifetch. Build with
// SERV_IFETCH_TIMEOUT_EN defined to exercise the ack timeout (TIMEOUT_CYCLES=4).
module tb_serv_ifetch;

`ifdef SERV_IFETCH_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 1000;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_fetch_req = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_flush = 1'b0;
    logic [31:0] i_ibus_rdt = '0;
    logic        i_ibus_ack = 1'b0;
    logic [31:0] o_ibus_adr;
    logic        o_ibus_cyc;
    logic        o_wb_en;
    logic [24:0] o_wb_rdt;
    logic        o_busy;
    logic        o_misalign;
    logic        o_fetch_err;

    serv_ifetch #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_fetch_req(i_fetch_req),
        .i_pc       (i_pc),
        .i_flush    (i_flush),
        .o_ibus_adr (o_ibus_adr),
        .o_ibus_cyc (o_ibus_cyc),
        .i_ibus_rdt (i_ibus_rdt),
        .i_ibus_ack (i_ibus_ack),
        .o_wb_en    (o_wb_en),
        .o_wb_rdt   (o_wb_rdt),
        .o_busy     (o_busy),
        .o_misalign (o_misalign),
        .o_fetch_err(o_fetch_err)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cycnt = 0;
    always @(posedge i_clk) cycnt <= cycnt + 1;

    int checks = 0;
    int errors = 0;

    // kind is {wb_en, fetch_err, misalign}
    typedef struct {
        logic [2:0]  kind;
        logic [24:0] data;
        int unsigned stamp;
    } ev_t;
    typedef struct {
        logic [31:0] adr;
        int unsigned len;
    } bus_t;

    ev_t         ev_q[$];
    bus_t        bus_q[$];
    logic [24:0] exp_wb_rdt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycnt);
        end
    endtask

    // Monitor: pulses and bus cycles are compared against queued expectations
    int unsigned run = 0;
    bus_t        cur;
    always @(negedge i_clk) begin
        ev_t        e;
        logic [2:0] act;
        act = {o_wb_en, o_fetch_err, o_misalign};
        if (act != 3'b000) begin
            if (ev_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, act}, 32'd0);
            end else begin
                e = ev_q.pop_front();
                check("pulse_kind", {29'd0, act}, {29'd0, e.kind});
                check("pulse_cycle", cycnt, e.stamp);
                if (e.kind == 3'b100)
                    check("wb_rdt_at_en", {7'd0, o_wb_rdt}, {7'd0, e.data});
            end
        end
        check("wb_rdt_hold", {7'd0, o_wb_rdt}, {7'd0, exp_wb_rdt});
        if (o_ibus_cyc) begin
            if (run == 0) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_cyc", 32'd1, 32'd0);
                    cur.adr = o_ibus_adr;
                    cur.len = 0;
                end else begin
                    cur = bus_q.pop_front();
                    check("ibus_adr", o_ibus_adr, cur.adr);
                end
            end else begin
                check("ibus_adr_stable", o_ibus_adr, cur.adr);
            end
            run++;
        end else if (run != 0) begin
            check("cyc_length", run, cur.len);
            run = 0;
        end
    end

    // Aligned fetch; n = ack wait cycles (n >= TMO means never acked).
    // flush_c: cycle index after acceptance to pulse i_flush (-1 none).
    task automatic do_fetch(input logic [31:0] pc, input int n, input logic [31:0] rdt,
                            input int flush_c, input logic [15:0] extra, input bit flush_idle);
        int unsigned r;
        bit          tmo;
        bit          supp;
        int          last;
        tmo = (n >= TMO);
        r   = cycnt;
        i_fetch_req = 1'b1;
        i_pc        = pc;
        i_flush     = flush_idle;
        bus_q.push_back('{adr: {pc[31:2], 2'b00}, len: tmo ? TMO : n + 1});
        supp = tmo ? (flush_c >= 0 && flush_c < TMO) : (flush_c >= 0 && flush_c <= n);
        if (!supp) begin
            if (tmo)
                ev_q.push_back('{kind: 3'b010, data: '0, stamp: r + TMO + 1});
            else if (rdt[1:0] != 2'b11)
                ev_q.push_back('{kind: 3'b010, data: '0, stamp: r + n + 2});
            else if (flush_c != n + 1)
                ev_q.push_back('{kind: 3'b100, data: rdt[31:7], stamp: r + n + 2});
        end
        @(posedge i_clk); #1;
        i_fetch_req = 1'b0;
        i_flush     = 1'b0;
        last = tmo ? TMO - 1 : n + 1;
        for (int c = 0; c <= last; c++) begin
            i_ibus_ack  = !tmo && (c == n);
            i_ibus_rdt  = (!tmo && c == n) ? rdt : $urandom;
            i_flush     = (c == flush_c);
            i_fetch_req = extra[c];
            i_pc        = $urandom;
            @(posedge i_clk); #1;
            if (i_ibus_ack) exp_wb_rdt = rdt[31:7];
            i_ibus_ack  = 1'b0;
            i_fetch_req = 1'b0;
            i_flush     = 1'b0;
        end
    endtask

    task automatic do_misalign();
        logic [31:0] pc;
        int unsigned r;
        pc = $urandom;
        if (pc[1:0] == 2'b00) pc[0] = 1'b1;
        r = cycnt;
        i_fetch_req = 1'b1;
        i_pc        = pc;
        ev_q.push_back('{kind: 3'b001, data: '0, stamp: r + 1});
        @(posedge i_clk); #1;
        i_fetch_req = 1'b0;
        check("misalign_busy", {31'd0, o_busy}, 32'd0);
        check("misalign_cyc", {31'd0, o_ibus_cyc}, 32'd0);
        @(posedge i_clk); #1;
    endtask

    // Reset asserted mid-cycle after k wait cycles with no ack
    task automatic do_reset_mid(input logic [31:0] pc, input int k);
        i_fetch_req = 1'b1;
        i_pc        = pc;
        bus_q.push_back('{adr: {pc[31:2], 2'b00}, len: k});
        @(posedge i_clk); #1;
        i_fetch_req = 1'b0;
        repeat (k) begin
            @(posedge i_clk); #1;
        end
        #2;
        i_rst = 1'b1;
        exp_wb_rdt = '0;
        #1;
        check("rst_cyc", {31'd0, o_ibus_cyc}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_pulses", {29'd0, o_wb_en, o_fetch_err, o_misalign}, 32'd0);
        check("rst_adr", o_ibus_adr, 32'd0);
        @(posedge i_clk);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
    endtask

    initial begin
        int          sel;
        int          n;
        int          fsel;
        int          fc;
        logic [31:0] rdt;
        logic [31:0] pc;

        repeat (2) @(posedge i_clk);
        #1;
        check("reset_cyc", {31'd0, o_ibus_cyc}, 32'd0);
        check("reset_busy", {31'd0, o_busy}, 32'd0);
        check("reset_pulses", {29'd0, o_wb_en, o_fetch_err, o_misalign}, 32'd0);
        check("reset_adr", o_ibus_adr, 32'd0);
        check("reset_wb_rdt", {7'd0, o_wb_rdt}, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        // Directed scenarios
        do_fetch(32'h0000_0100, 2, 32'h00A0_0093, -1, 16'h0000, 1'b0);
        check("wb_rdt_example", {7'd0, o_wb_rdt}, 32'h0001_4001);
        do_misalign();
        do_fetch(32'h0000_0104, 2, 32'h0000_0013, 0, 16'h0000, 1'b0);
        check("idle_after_flush", {31'd0, o_busy}, 32'd0);
        do_fetch(32'h0000_0108, 2, 32'h0000_0013, -1, 16'hFFFF, 1'b0);
        do_reset_mid(32'h0000_0300, 2);
        do_fetch(32'h0000_0200, 1, 32'h0010_0093, -1, 16'h0000, 1'b0);
        do_fetch(32'h0000_0204, 0, 32'h0000_0000, -1, 16'h0000, 1'b0);
        do_fetch(32'h0000_0208, 0, 32'h0000_0013, 1, 16'h0000, 1'b1);
        do_fetch(32'h0000_020C, 6, 32'h0000_0013, -1, 16'h0000, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            sel = $urandom_range(0, 9);
            pc  = $urandom;
            pc[1:0] = 2'b00;
            if (sel == 0) begin
                do_misalign();
            end else if (sel == 1) begin
                do_reset_mid(pc, $urandom_range(1, 3));
            end else begin
                n   = $urandom_range(0, 7);
                rdt = $urandom;
                if ($urandom_range(0, 3) != 0) rdt[1:0] = 2'b11;
                fsel = $urandom_range(0, 5);
                fc   = (fsel == 0) ? $urandom_range(0, n) : (fsel == 1) ? n + 1 : -1;
                do_fetch(pc, n, rdt, fc,
                         ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000,
                         $urandom_range(0, 7) == 0);
            end
        end

        repeat (5) @(posedge i_clk);
        #1;
        check("events_left", ev_q.size(), 32'd0);
        check("bus_left", bus_q.size(), 32'd0);
        check("cyc_idle_end", {31'd0, o_ibus_cyc}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
